// File: rtl/bus_master_arbiter_pkg.sv
// Shared types and constants for the two-master bus arbiter.
// Optional bus locking for the debug master is enabled with BUS_ARB_LOCK_EN.
package bus_master_arbiter_pkg;

   localparam int WORD_W  = 32;
   localparam int BSEL_W  = 4;
   localparam int BURST_W = 4;
   localparam int TMO_W   = 8;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [BSEL_W-1:0] bsel_t;

   // Returned to the master in place of read data when a slave never answers.
   localparam word_t BUS_ERR_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_XFER = 2'd1,
      ARB_RESP = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bus_master_arbiter_pick.sv
// Owner selection for the bus arbiter: fixed m0 priority with a burst limit
// that forces m1 in, plus the next value of the burst counter.
module bus_master_arbiter_pick
   import bus_master_arbiter_pkg::*;
#(
   parameter int MAX_BURST = 4
)(
   input  logic               m0_req,
   input  logic               m1_req,
   input  logic               lock_active,
   input  logic [BURST_W-1:0] burst_cnt,
   output logic               grant_valid,
   output logic               grant_owner,
   output logic [BURST_W-1:0] burst_next
);

   localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_BURST);

   always_comb begin
      grant_valid = 1'b0;
      grant_owner = 1'b0;
      burst_next  = burst_cnt;
      if (lock_active) begin
         // Locked for m1: m0 is ignored and the burst history is frozen.
         if (m1_req) begin
            grant_valid = 1'b1;
            grant_owner = 1'b1;
         end
      end else if (m0_req && m1_req) begin
         grant_valid = 1'b1;
         if (burst_cnt >= BURST_LIMIT) begin
            grant_owner = 1'b1;
            burst_next  = '0;
         end else begin
            grant_owner = 1'b0;
            burst_next  = burst_cnt + BURST_W'(1);
         end
      end else if (m0_req) begin
         grant_valid = 1'b1;
         grant_owner = 1'b0;
         burst_next  = '0;
      end else if (m1_req) begin
         grant_valid = 1'b1;
         grant_owner = 1'b1;
         burst_next  = '0;
      end
   end

endmodule

// File: rtl/bus_master_arbiter.sv
// Two-master single-word bus sequencer with timeout and burst fairness.
// Define BUS_ARB_LOCK_EN to add the m1_lock input for atomic debug accesses.
module bus_master_arbiter
   import bus_master_arbiter_pkg::*;
#(
   parameter int TIMEOUT   = 15,
   parameter int MAX_BURST = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic [WORD_W-1:0] m0_addr,
   input  logic              m0_we,
   input  logic [BSEL_W-1:0] m0_byte_sel,
   input  logic [WORD_W-1:0] m0_wdata,
   output logic [WORD_W-1:0] m0_rdata,
   output logic              m0_ack,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic [WORD_W-1:0] m1_addr,
   input  logic              m1_we,
   input  logic [BSEL_W-1:0] m1_byte_sel,
   input  logic [WORD_W-1:0] m1_wdata,
   output logic [WORD_W-1:0] m1_rdata,
   output logic              m1_ack,
   output logic              m1_err,
`ifdef BUS_ARB_LOCK_EN
   input  logic              m1_lock,
`endif
   output logic [WORD_W-1:0] bus_addr_out,
   output logic [WORD_W-1:0] bus_write_data_out,
   output logic              bus_eable_out,
   output logic              bus_we_out,
   output logic [BSEL_W-1:0] bus_byte_sel_out,
   input  logic [WORD_W-1:0] bus_read_in,
   input  logic              bus_ready_in,
   output logic              owner_out
);

   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

   arb_state_t         state_reg, state_next;
   logic               owner_reg;
   word_t              addr_reg;
   word_t              wdata_reg;
   logic               we_reg;
   bsel_t              byte_sel_reg;
   logic [BURST_W-1:0] burst_reg, burst_next;
   logic [TMO_W-1:0]   tmo_reg, tmo_next;
   word_t              m0_rdata_reg;
   word_t              m1_rdata_reg;
   logic               err_reg;
   logic               lock_reg, lock_next;
   logic               lock_hold;
   logic               lock_active;
   logic               grant_valid;
   logic               grant_owner;
   logic [BURST_W-1:0] pick_burst;
   logic               load;
   logic               complete;
   logic               timed_out;

`ifdef BUS_ARB_LOCK_EN
   assign lock_hold = m1_lock;
`else
   assign lock_hold = 1'b0;
`endif
   assign lock_active = lock_reg & lock_hold;

   bus_master_arbiter_pick #(
      .MAX_BURST (MAX_BURST)
   ) u_pick (
      .m0_req      (m0_req),
      .m1_req      (m1_req),
      .lock_active (lock_active),
      .burst_cnt   (burst_reg),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner),
      .burst_next  (pick_burst)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ARB_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      burst_next = burst_reg;
      tmo_next   = tmo_reg;
      lock_next  = lock_reg;
      load       = 1'b0;
      complete   = 1'b0;
      timed_out  = 1'b0;
      case (state_reg)
         ARB_IDLE: begin
            if (!lock_hold) begin
               lock_next = 1'b0;
            end
            if (grant_valid) begin
               state_next = ARB_XFER;
               load       = 1'b1;
               burst_next = pick_burst;
            end
         end
         ARB_XFER: begin
            tmo_next = tmo_reg + TMO_W'(1);
            // A ready on the final allowed cycle still counts as success.
            if (bus_ready_in) begin
               complete   = 1'b1;
               state_next = ARB_RESP;
            end else if (tmo_reg == TMO_LAST) begin
               complete   = 1'b1;
               timed_out  = 1'b1;
               state_next = ARB_RESP;
            end
         end
         ARB_RESP: begin
            tmo_next   = '0;
            lock_next  = owner_reg & lock_hold;
            state_next = ARB_IDLE;
         end
         default: begin
            state_next = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_reg    <= 1'b0;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         we_reg       <= 1'b0;
         byte_sel_reg <= '0;
         burst_reg    <= '0;
         tmo_reg      <= '0;
         lock_reg     <= 1'b0;
         m0_rdata_reg <= '0;
         m1_rdata_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         burst_reg <= burst_next;
         tmo_reg   <= tmo_next;
         lock_reg  <= lock_next;
         if (load) begin
            owner_reg    <= grant_owner;
            addr_reg     <= grant_owner ? m1_addr     : m0_addr;
            wdata_reg    <= grant_owner ? m1_wdata    : m0_wdata;
            we_reg       <= grant_owner ? m1_we       : m0_we;
            byte_sel_reg <= grant_owner ? m1_byte_sel : m0_byte_sel;
         end
         if (complete) begin
            err_reg <= timed_out;
            if (owner_reg) begin
               m1_rdata_reg <= timed_out ? BUS_ERR_WORD : bus_read_in;
            end else begin
               m0_rdata_reg <= timed_out ? BUS_ERR_WORD : bus_read_in;
            end
         end
      end
   end

   assign bus_addr_out       = addr_reg;
   assign bus_write_data_out = wdata_reg;
   assign bus_byte_sel_out   = byte_sel_reg;
   assign bus_eable_out      = (state_reg == ARB_XFER);
   assign bus_we_out         = (state_reg == ARB_XFER) & we_reg;
   assign owner_out          = owner_reg;

   assign m0_ack   = (state_reg == ARB_RESP) & ~owner_reg;
   assign m1_ack   = (state_reg == ARB_RESP) &  owner_reg;
   assign m0_err   = m0_ack & err_reg;
   assign m1_err   = m1_ack & err_reg;
   assign m0_rdata = m0_rdata_reg;
   assign m1_rdata = m1_rdata_reg;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: a transfer-level model checked every
// cycle plus literal expectations per scenario. Lock scenario needs BUS_ARB_LOCK_EN.
module tb_bus_master_arbiter;

   localparam int TIMEOUT   = 15;
   localparam int MAX_BURST = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_byte_sel, m1_byte_sel;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [31:0] bus_addr_out, bus_write_data_out, bus_read_in;
   logic        bus_eable_out, bus_we_out, bus_ready_in, owner_out;
   logic [3:0]  bus_byte_sel_out;
   logic        lk_in;
`ifdef BUS_ARB_LOCK_EN
   logic        m1_lock;
   assign lk_in = m1_lock;
`else
   assign lk_in = 1'b0;
`endif

   bus_master_arbiter #(.TIMEOUT(TIMEOUT), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_byte_sel(m0_byte_sel),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_byte_sel(m1_byte_sel),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
`ifdef BUS_ARB_LOCK_EN
      .m1_lock(m1_lock),
`endif
      .bus_addr_out(bus_addr_out), .bus_write_data_out(bus_write_data_out),
      .bus_eable_out(bus_eable_out), .bus_we_out(bus_we_out),
      .bus_byte_sel_out(bus_byte_sel_out), .bus_read_in(bus_read_in),
      .bus_ready_in(bus_ready_in), .owner_out(owner_out)
   );

   initial forever #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Transfer-level model: t counts strobe cycles of the active transfer (0 = none).
   bit          model_live = 1'b0;
   int          t, burst, g_m;
   bit          resp, ow, we_m, locked, er;
   logic [31:0] a_m, wd_m, rd0, rd1, v_m;
   logic [3:0]  bs_m;

   task automatic model_step();
      if (rst) begin
         t = 0; resp = 0; ow = 0; we_m = 0; locked = 0; er = 0; burst = 0;
         a_m = '0; wd_m = '0; bs_m = '0; rd0 = '0; rd1 = '0;
         model_live = 1'b1;
      end else if (model_live) begin
         if (resp) begin
            resp   = 0;
            locked = ow && lk_in;
         end else if (t > 0) begin
            if (bus_ready_in || t == TIMEOUT) begin
               v_m = bus_ready_in ? bus_read_in : 32'hFFFF_FFFF;
               if (ow) rd1 = v_m; else rd0 = v_m;
               er   = !bus_ready_in;
               resp = 1;
               t    = 0;
            end else begin
               t++;
            end
         end else begin
            g_m = -1;
            if (locked && !lk_in) locked = 0;
            if (locked) begin
               if (m1_req) g_m = 1;
            end else if (m0_req && m1_req) begin
               if (burst == MAX_BURST) begin g_m = 1; burst = 0; end
               else begin g_m = 0; burst++; end
            end else if (m0_req) begin
               g_m = 0; burst = 0;
            end else if (m1_req) begin
               g_m = 1; burst = 0;
            end
            if (g_m >= 0) begin
               ow   = (g_m == 1);
               t    = 1;
               a_m  = ow ? m1_addr     : m0_addr;
               wd_m = ow ? m1_wdata    : m0_wdata;
               we_m = ow ? m1_we       : m0_we;
               bs_m = ow ? m1_byte_sel : m0_byte_sel;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (model_live) begin
         chk("eable",    bus_eable_out,      32'(t > 0));
         chk("we",       bus_we_out,         32'((t > 0) && we_m));
         chk("addr",     bus_addr_out,       a_m);
         chk("wdata",    bus_write_data_out, wd_m);
         chk("bsel",     bus_byte_sel_out,   32'(bs_m));
         chk("m0_ack",   m0_ack,             32'(resp && !ow));
         chk("m1_ack",   m1_ack,             32'(resp && ow));
         chk("m0_err",   m0_err,             32'(resp && !ow && er));
         chk("m1_err",   m1_err,             32'(resp && ow && er));
         chk("m0_rdata", m0_rdata,           rd0);
         chk("m1_rdata", m1_rdata,           rd1);
         chk("owner",    owner_out,          32'(ow));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int          k, e1, a1, n, strobes, we_hi, n0, n1;
   logic [31:0] r, sa, sd, sb;
   logic        er_s, got;
   int          seq[10];
   int          exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      rst = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = 32'h1111_0000; m0_byte_sel = 4'hF;
      m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = 32'h2222_0000; m1_byte_sel = 4'hF;
      bus_read_in = '0; bus_ready_in = 1'b1;
`ifdef BUS_ARB_LOCK_EN
      m1_lock = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_eable", bus_eable_out, 0);
      chk("rst_addr", bus_addr_out, 0);
      chk("rst_owner", owner_out, 0);
      chk("rst_m0_rdata", m0_rdata, 0);

      // m0 read, zero-wait slave
      @(posedge clk); #1;
      k = cyc; bus_read_in = 32'h1234_5678; m0_addr = 32'h10; m0_we = 0; m0_req = 1;
      e1 = -1; a1 = -1;
      for (int i = 0; i < 10 && a1 < 0; i++) begin
         @(negedge clk);
         if (bus_eable_out && e1 < 0) e1 = cyc;
         if (m0_ack) begin a1 = cyc; r = m0_rdata; er_s = m0_err; end
      end
      @(posedge clk); #1 m0_req = 0;
      chk("t1_strobe_cyc", e1, k + 1);
      chk("t1_ack_cyc", a1, k + 2);
      chk("t1_rdata", r, 32'h1234_5678);
      chk("t1_err", er_s, 0);

      // Both masters requesting continuously
      @(posedge clk); #1;
      m0_addr = 32'h100; m1_addr = 32'h200; bus_read_in = 32'h0BAD_0000;
      m0_req = 1; m1_req = 1; n = 0;
      for (int i = 0; i < 100 && n < 10; i++) begin
         @(negedge clk);
         if (m0_ack) begin seq[n] = 0; n++; end
         else if (m1_ack) begin seq[n] = 1; n++; end
      end
      @(posedge clk); #1 m0_req = 0; m1_req = 0;
      chk("t2_grant_count", n, 10);
      for (int i = 0; i < 10; i++) chk($sformatf("t2_grant%0d", i), seq[i], exp_seq[i]);

      // m1 write, ready arrives on the 4th strobe cycle
      @(posedge clk); #1;
      bus_ready_in = 0; m1_addr = 32'hFFFF_FC60; m1_wdata = 32'hA5; m1_byte_sel = 4'b0001;
      m1_we = 1; m1_req = 1;
      strobes = 0; we_hi = 0; n0 = 0; n1 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_we_out) we_hi++;
         if (m0_ack) n0++;
         if (m1_ack) n1++;
         if (bus_eable_out) begin
            strobes++;
            if (strobes == 1) begin sa = bus_addr_out; sd = bus_write_data_out; sb = 32'(bus_byte_sel_out); end
            if (strobes == 3) begin @(posedge clk); #1 bus_ready_in = 1; end
         end
         if (m1_ack) begin @(posedge clk); #1 m1_req = 0; m1_we = 0; end
      end
      chk("t3_we_cycles", we_hi, 4);
      chk("t3_m1_acks", n1, 1);
      chk("t3_m0_acks", n0, 0);
      chk("t3_addr", sa, 32'hFFFF_FC60);
      chk("t3_wdata", sd, 32'hA5);
      chk("t3_bsel", sb, 32'h1);

      // Timeout: slave never ready
      @(posedge clk); #1;
      bus_ready_in = 0; bus_read_in = 32'h55AA_55AA; m0_addr = 32'h20; m0_req = 1;
      strobes = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus_eable_out) strobes++;
         if (m0_ack) begin got = 1; r = m0_rdata; er_s = m0_err; end
      end
      @(posedge clk); #1 m0_req = 0;
      chk("t4_got_ack", got, 1);
      chk("t4_strobes", strobes, TIMEOUT);
      chk("t4_rdata", r, 32'hFFFF_FFFF);
      chk("t4_err", er_s, 1);

      // Ready on the last allowed cycle beats the timeout
      @(posedge clk); #1;
      bus_read_in = 32'hCAFE_F00D; m0_req = 1; strobes = 0; got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus_eable_out) begin
            strobes++;
            if (strobes == TIMEOUT - 1) begin @(posedge clk); #1 bus_ready_in = 1; end
         end
         if (m0_ack) begin got = 1; r = m0_rdata; er_s = m0_err; end
      end
      @(posedge clk); #1 m0_req = 0;
      chk("t4b_got_ack", got, 1);
      chk("t4b_strobes", strobes, TIMEOUT);
      chk("t4b_rdata", r, 32'hCAFE_F00D);
      chk("t4b_err", er_s, 0);

      // Reset in the middle of a transfer, request kept high
      @(posedge clk); #1;
      bus_ready_in = 0; bus_read_in = 32'h0000_3030; m0_addr = 32'h30; m0_req = 1;
      strobes = 0;
      for (int i = 0; i < 10 && strobes < 2; i++) begin
         @(negedge clk);
         if (bus_eable_out) strobes++;
      end
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0; bus_ready_in = 1;
      @(negedge clk);
      chk("t5_eable_after_rst", bus_eable_out, 0);
      chk("t5_m0_ack_after_rst", m0_ack, 0);
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (m0_ack) begin got = 1; r = m0_rdata; end
      end
      @(posedge clk); #1 m0_req = 0;
      chk("t5_regrant_ack", got, 1);
      chk("t5_regrant_rdata", r, 32'h0000_3030);

`ifdef BUS_ARB_LOCK_EN
      // m1 holds the lock; m0 must wait until it is released
      @(posedge clk); #1;
      m1_lock = 1; m1_req = 1; m1_we = 0; m1_addr = 32'h40;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (m1_ack) got = 1;
      end
      @(posedge clk); #1 m1_req = 0; m0_req = 1; m0_addr = 32'h44;
      chk("t6_m1_ack", got, 1);
      n0 = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_eable_out && !owner_out) n0++;
      end
      chk("t6_m0_stalled", n0, 0);
      @(posedge clk); #1 m1_lock = 0; k = cyc;
      e1 = -1; got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (bus_eable_out && !owner_out && e1 < 0) e1 = cyc;
         if (m0_ack) got = 1;
      end
      @(posedge clk); #1 m0_req = 0;
      chk("t6_m0_grant_cyc", e1, k + 1);
      chk("t6_m0_ack", got, 1);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
